// File: rtl/i2c_scl_if.sv
// I2C SCL generator bus: run/config inputs, pad sense and
// timing strobes shared between the bit controller and generator.
interface i2c_scl_if #(
  parameter int CNT_W = 16,
  parameter int TO_W  = 20
);
  logic             en_clk;
  logic [CNT_W-1:0] div_val;
  logic [TO_W-1:0]  to_val;
  logic             scl_in;
  logic             scl_o;
  logic             scl_negedge;
  logic             scl_low_mid;
  logic             scl_posedge;
  logic             scl_high_mid;
  logic             busy;
  logic             stretching;
  logic             stretch_to;

  modport master (
    output en_clk,
    output div_val,
    output to_val,
    output scl_in,
    input  scl_o,
    input  scl_negedge,
    input  scl_low_mid,
    input  scl_posedge,
    input  scl_high_mid,
    input  busy,
    input  stretching,
    input  stretch_to
  );

  modport slave (
    input  en_clk,
    input  div_val,
    input  to_val,
    input  scl_in,
    output scl_o,
    output scl_negedge,
    output scl_low_mid,
    output scl_posedge,
    output scl_high_mid,
    output busy,
    output stretching,
    output stretch_to
  );
endinterface

// File: rtl/i2c_scl_gen.sv
// Four-phase I2C SCL generator with programmable quarter period,
// edge/mid strobes, clock-stretch hold and stretch timeout.
module i2c_scl_gen #(
  parameter int CNT_W = 16,
  parameter int TO_W  = 20
) (
  input  logic     clk,
  input  logic     rst,
  i2c_scl_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    P0,
    P1,
    P2,
    P3
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] div_q, div_d;
  logic [TO_W-1:0]  st_cnt_q, st_cnt_d;
  logic             to_q, to_d;

  logic             cnt0;
  logic             cnt_end;
  logic             stall;
  logic             timeout;
  logic [CNT_W-1:0] div_eff;

  assign cnt0    = (cnt_q == '0);
  assign cnt_end = (cnt_q == div_q);
  assign div_eff = (bus.div_val == '0) ? CNT_W'(1)
                                       : bus.div_val;

  // P2 cycle 0 is held until the pad actually goes high
  assign stall   = (state_q == P2) && cnt0 && !bus.scl_in;
  assign timeout = stall && (bus.to_val != '0)
                   && (st_cnt_q == bus.to_val);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      div_q    <= CNT_W'(1);
      st_cnt_q <= '0;
      to_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      st_cnt_q <= st_cnt_d;
      to_q     <= to_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    div_d    = div_q;
    st_cnt_d = st_cnt_q;
    to_d     = to_q;
    if (!bus.en_clk) to_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.en_clk && !to_q) begin
          state_d = P0;
          cnt_d   = '0;
          div_d   = div_eff;
        end
      end
      P0: begin
        if (cnt_end) begin
          state_d = P1;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      P1: begin
        if (cnt_end) begin
          state_d  = P2;
          cnt_d    = '0;
          st_cnt_d = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      P2: begin
        if (timeout) begin
          state_d = IDLE;
          cnt_d   = '0;
          to_d    = 1'b1;
        end else if (stall) begin
          st_cnt_d = st_cnt_q + TO_W'(1);
        end else if (cnt_end) begin
          state_d = P3;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      P3: begin
        if (cnt_end) begin
          cnt_d = '0;
          if (bus.en_clk) begin
            state_d = P0;
            div_d   = div_eff;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    bus.scl_o        = 1'b1;
    bus.scl_negedge  = 1'b0;
    bus.scl_low_mid  = 1'b0;
    bus.scl_posedge  = 1'b0;
    bus.scl_high_mid = 1'b0;
    bus.busy         = (state_q != IDLE);
    bus.stretching   = stall;
    bus.stretch_to   = to_q;
    unique case (state_q)
      P0: begin
        bus.scl_o       = 1'b0;
        bus.scl_negedge = cnt0;
      end
      P1: begin
        bus.scl_o       = 1'b0;
        bus.scl_low_mid = cnt0;
      end
      P2: bus.scl_posedge  = cnt0 && bus.scl_in;
      P3: bus.scl_high_mid = cnt0;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_i2c_scl_gen.sv
// Directed bench for i2c_scl_gen: period shape, graceful stop,
// divider reload, stretch, timeout and mid-period reset.
module tb_i2c_scl_gen;

  localparam logic [7:0] IDLE_V = 8'b0000_1000;
  localparam logic [7:0] TO_V   = 8'b0000_1001;

  logic clk = 1'b0;
  logic rst;
  logic force_low;
  int   n_chk;
  int   n_fail;
  logic [7:0] got, want;
  logic found;

  i2c_scl_if #(.CNT_W(16), .TO_W(20)) bus ();

  i2c_scl_gen #(.CNT_W(16), .TO_W(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // open-drain pad: target may hold SCL low
  assign bus.scl_in = bus.scl_o & ~force_low;

  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {bus.scl_negedge, bus.scl_low_mid,
            bus.scl_posedge, bus.scl_high_mid,
            bus.scl_o, bus.busy,
            bus.stretching, bus.stretch_to};
  endfunction

  // {neg,lmid,pos,hmid,scl_o,busy,stretching,to}
  function automatic logic [7:0] exp_vec(
    int o, int q, int s);
    logic [7:0] v;
    v = 8'b0000_0100;
    if (o == 0)         v[7] = 1'b1;
    if (o == q)         v[6] = 1'b1;
    if (o == 2*q + s)   v[5] = 1'b1;
    if (o == 3*q + s)   v[4] = 1'b1;
    v[3] = (o >= 2*q);
    v[1] = (o >= 2*q) && (o < 2*q + s);
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_low_mid();
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick();
      #1;
      if (bus.scl_low_mid) found = 1'b1;
    end
    n_chk++;
    if (found !== 1'b1) begin
      n_fail++;
      $display("FAIL low_mid_wait got %b want 1", found);
    end
  endtask

  task automatic stop_idle();
    bus.en_clk = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      tick();
      #1;
      if (!bus.busy) found = 1'b1;
    end
    n_chk++;
    if (found !== 1'b1) begin
      n_fail++;
      $display("FAIL stop_idle busy stuck got %b want 1", found);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.en_clk = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
    got = obs();
    n_chk++;
    if (got !== IDLE_V) begin
      n_fail++;
      $display("FAIL reset got %b want %b", got, IDLE_V);
    end
    for (int i = 0; i < 20; i++) begin
      tick();
      #1;
      got = obs();
      n_chk++;
      if (got !== IDLE_V) begin
        n_fail++;
        $display("FAIL reset_idle c=%0d got %b want %b",
                 i, got, IDLE_V);
      end
    end
  endtask

  task automatic test_basic_run();
    bus.div_val = 16'd4;
    bus.to_val  = 20'd0;
    tick();
    bus.en_clk = 1'b1;
    #1;
    got = obs();
    n_chk++;
    if (got !== IDLE_V) begin
      n_fail++;
      $display("FAIL basic_pre got %b want %b", got, IDLE_V);
    end
    for (int o = 0; o < 40; o++) begin
      tick();
      #1;
      got  = obs();
      want = exp_vec(o % 20, 5, 0);
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL basic o=%0d got %b want %b",
                 o, got, want);
      end
    end
  endtask

  task automatic test_graceful_stop();
    wait_low_mid();
    bus.div_val = 16'd9;
    for (int o = 6; o <= 30; o++) begin
      tick();
      if (o == 6) bus.en_clk = 1'b0;
      #1;
      got  = obs();
      want = (o < 20) ? exp_vec(o, 5, 0) : IDLE_V;
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL stop o=%0d got %b want %b",
                 o, got, want);
      end
    end
  endtask

  task automatic test_restart_div();
    tick();
    bus.en_clk = 1'b1;
    #1;
    for (int o = 0; o <= 40; o++) begin
      tick();
      #1;
      got  = obs();
      want = exp_vec(o % 40, 10, 0);
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL restart40 o=%0d got %b want %b",
                 o, got, want);
      end
    end
    stop_idle();
  endtask

  task automatic test_min_div();
    bus.div_val = 16'd0;
    tick();
    bus.en_clk = 1'b1;
    #1;
    for (int o = 0; o <= 8; o++) begin
      tick();
      #1;
      got  = obs();
      want = exp_vec(o % 8, 2, 0);
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL min_div o=%0d got %b want %b",
                 o, got, want);
      end
    end
    stop_idle();
  endtask

  task automatic test_stretch();
    bus.div_val = 16'd2;
    bus.to_val  = 20'd0;
    tick();
    bus.en_clk = 1'b1;
    #1;
    for (int o = 0; o <= 19; o++) begin
      tick();
      force_low = (o >= 6) && (o <= 12);
      #1;
      got  = obs();
      want = exp_vec(o % 19, 3, 7);
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL stretch o=%0d got %b want %b",
                 o, got, want);
      end
    end
    stop_idle();
  endtask

  task automatic test_timeout();
    bus.div_val = 16'd2;
    bus.to_val  = 20'd10;
    tick();
    bus.en_clk = 1'b1;
    force_low  = 1'b1;
    #1;
    for (int o = 0; o <= 16; o++) begin
      tick();
      #1;
      got  = obs();
      want = exp_vec(o, 3, 100);
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL to_run o=%0d got %b want %b",
                 o, got, want);
      end
    end
    tick();
    #1;
    got = obs();
    n_chk++;
    if (got !== TO_V) begin
      n_fail++;
      $display("FAIL to_fire got %b want %b", got, TO_V);
    end
    force_low = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      #1;
      got = obs();
      n_chk++;
      if (got !== TO_V) begin
        n_fail++;
        $display("FAIL to_hold c=%0d got %b want %b",
                 i, got, TO_V);
      end
    end
    tick();
    bus.en_clk = 1'b0;
    tick();
    bus.en_clk = 1'b1;
    #1;
    got = obs();
    n_chk++;
    if (got !== IDLE_V) begin
      n_fail++;
      $display("FAIL to_clear got %b want %b", got, IDLE_V);
    end
    tick();
    #1;
    got  = obs();
    want = exp_vec(0, 3, 0);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL to_restart got %b want %b", got, want);
    end
    bus.to_val = 20'd0;
    stop_idle();
  endtask

  task automatic test_reset_mid();
    bus.div_val = 16'd4;
    tick();
    bus.en_clk = 1'b1;
    wait_low_mid();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    got = obs();
    n_chk++;
    if (got !== IDLE_V) begin
      n_fail++;
      $display("FAIL rst_mid got %b want %b", got, IDLE_V);
    end
    for (int o = 0; o < 20; o++) begin
      tick();
      #1;
      got  = obs();
      want = exp_vec(o, 5, 0);
      n_chk++;
      if (got !== want) begin
        n_fail++;
        $display("FAIL rst_restart o=%0d got %b want %b",
                 o, got, want);
      end
    end
    stop_idle();
  endtask

  initial begin
    n_chk       = 0;
    n_fail      = 0;
    rst         = 1'b1;
    force_low   = 1'b0;
    bus.en_clk  = 1'b0;
    bus.div_val = 16'd4;
    bus.to_val  = 20'd0;
    test_reset();
    test_basic_run();
    test_graceful_stop();
    test_restart_div();
    test_min_div();
    test_stretch();
    test_timeout();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/i2c_scl_gen.md
# i2c_scl_gen

Parametrised I2C SCL timing generator: the programmable, stretch-aware successor to the fixed divider. It divides `clk` into a four-phase SCL period with a runtime-programmable quarter length. It emits single-cycle strobes at both SCL edges and at the mid-low and mid-high points. It honours target clock stretching and flags a stretch timeout. It sits between the byte/bit controller, which consumes the strobes, and the open-drain SCL pad.

## Interface
- `CNT_W`, 16: width of quarter-period counter and `div_val`.
- `TO_W`, 20: width of stretch-timeout counter and `to_val`.

- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `en_clk`  in  1  run request; level-sensitive.
- `div_val`  in  CNT_W  quarter period minus one; effective minimum 1.
- `to_val`  in  TO_W  stretch timeout in `clk` cycles; 0 disables timeout.
- `scl_in`  in  1  SCL pad level, already synchronised upstream.
- `scl_o`  out  1  1 = release SCL, 0 = drive low.
- `scl_negedge`  out  1  strobe, first cycle of phase 0.
- `scl_low_mid`  out  1  strobe, first cycle of phase 1 (SDA change point).
- `scl_posedge`  out  1  strobe, first counted cycle of phase 2.
- `scl_high_mid`  out  1  strobe, first cycle of phase 3 (SDA sample point).
- `busy`  out  1  generator not idle.
- `stretching`  out  1  SCL released but held low externally.
- `stretch_to`  out  1  sticky timeout flag.

## Operation
- States: IDLE, P0 (low, first half), P1 (low, second half), P2 (high, first half), P3 (high, second half).
- Quarter length Q = max(`div_val`,1)+1 cycles. `div_val` is latched into `div_q` on every entry to P0; mid-period changes take effect at the next negedge.
- `cnt` runs 0..Q-1 within each phase. At Q-1 the state advances and `cnt` returns to 0.
- IDLE → P0 when `en_clk`=1 and `stretch_to`=0.
- P3 end → P0 if `en_clk`=1, else IDLE.
- Deasserting `en_clk` never truncates a period. The current period completes through P3 before IDLE.
- `scl_o` = 0 in P0/P1, and 1 in IDLE/P2/P3.
- Stretch:
  - In P2, while `scl_in`=0, `cnt` holds at 0, `stretching`=1, and `st_cnt` increments.
  - The first cycle with `scl_in`=1 is the P2 counted cycle 0: `scl_posedge` pulses and `stretching` drops.
  - `st_cnt` clears on P2 entry.
- Timeout:
  - If `to_val`≠0 and `st_cnt` reaches `to_val`, set `stretch_to` and go to IDLE (SCL stays released).
  - `stretch_to` clears only when `en_clk`=0 or on `rst`.
  - No restart is allowed while it is set.
- Strobes are mutually exclusive. Each fires exactly once per SCL period.

## Timing
- Reset values: state IDLE, `cnt`=0, `scl_o`=1, all strobes 0, `busy`=0, `stretching`=0, `stretch_to`=0, `div_q`=1.
- `rst` overrides everything, mid-period included. The next cycle shows reset values and SCL released immediately.
- Start latency: `en_clk` sampled 1 in IDLE at edge N gives P0 from edge N+1. `scl_negedge`=1 and `scl_o`=0 in the cycle after edge N.
- Strobes decode registered state/`cnt`. `scl_posedge` additionally gates on `scl_in`.
- Unstretched period = 4Q cycles. Strobe spacing is Q cycles.
- Stretch of S cycles extends the period to 4Q+S. P2 still counts Q cycles after release.
- `busy` = 1 in every non-IDLE state, including the cycle of `scl_negedge`.
- Timeout fires on the cycle `st_cnt`==`to_val`. `stretch_to` is set and `busy` is 0 in the following cycle.

## Test plan
- Reset/idle: assert `rst` 2 cycles with `en_clk`=0 → `scl_o`=1, all strobes 0, `busy`=0 for 20 cycles.
- Basic run: `div_val`=4, `scl_in` follows `scl_o`, `en_clk`=1 → period 20 cycles; negedge/low_mid/posedge/high_mid at offsets 0/5/10/15; first `scl_negedge` one cycle after `en_clk` sampled.
- Graceful stop and div change: `div_val` changed 4→9 during P1, then `en_clk` dropped in P1 → current period stays 20 cycles; no second period starts; IDLE after P3; `busy` falls at that edge. Restart gives a 40-cycle period.
- Stretch: `div_val`=2, `to_val`=0, hold `scl_in`=0 for 7 cycles into P2 → `stretching`=1 for 7 cycles; `scl_posedge` on 8th; period = 19 cycles.
- Timeout: `to_val`=10, `scl_in` held 0 → `stretch_to`=1, `busy`=0, `scl_o`=1. No restart while `en_clk`=1. Flag clears after `en_clk`=0 for one cycle.
- Reset mid-period: assert `rst` in P1 → next cycle `scl_o`=1, IDLE. After release with `en_clk`=1, clean restart at P0.
